gamepad_pmod_rx: RTL
====================

Name: gamepad_pmod_rx

Overview:
Receiver front-end for the gamepad PMOD. It samples the PMOD's serial link (data/clock/latch) in the system clock domain, shifts in one frame of 12 bits per controller, and on latch publishes a registered, presence-masked button vector. It sits directly upstream of the gamepad demo top level, which consumes `buttons`/`present` to drive its display logic.

Parameters:
NUM_CTRL, 2, number of controllers per frame (1 or 2); frame length NUM_BITS = 12*NUM_CTRL
TIMEOUT_CYCLES, 2_500_000, clk cycles without a valid frame before outputs are cleared (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pmod_data  input  1  serial button data, async to clk
pmod_clk  input  1  serial shift clock, async to clk
pmod_latch  input  1  frame latch strobe, async to clk
buttons  output  12*NUM_CTRL  button state, 1 = pressed; controller k in [12k+11:12k]
present  output  NUM_CTRL  controller k connected
frame_valid  output  1  1-cycle pulse when buttons/present update
frame_err  output  1  1-cycle pulse when a latch arrives with wrong bit count

Behaviour:
- Reset, asynchronous and active-high: all outputs 0, shift register 0, bit counter 0, synchronizers 0.
- Each of pmod_data, pmod_clk and pmod_latch passes through a 2-FF synchronizer. A third register per signal provides edge detection; a rising edge is sync2 & ~sync3. pmod_data is sampled at its sync2 stage.
- Rising edge on pmod_clk:
  - sr <= {sr[NUM_BITS-2:0], data_sync}.
  - bitcnt increments, saturating at NUM_BITS+1.
- Rising edge on pmod_latch:
  - If bitcnt == NUM_BITS, the frame is good:
    - Next cycle: buttons and present update, and frame_valid = 1 for exactly 1 cycle.
    - Per controller k, the slice s = sr[12k+11:12k] (the last 12 bits received form controller 0).
    - present[k] = ~&s (an all-ones slice means no controller).
    - buttons slice = present[k] ? s : 12'h000.
  - Otherwise the frame is bad: frame_err = 1 for 1 cycle, and buttons/present hold their values.
  - In both cases bitcnt <= 0. sr is not cleared.
- Slice bit order, bit 11 down to bit 0: B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R.
- Simultaneous rising edges on clk and latch in the same cycle: the shift (and count) happens first, and the latch evaluates the post-shift sr and bitcnt.
- Latency: a pmod_latch rising edge at the pin produces frame_valid 4 clk cycles later (2 synchronizer stages, edge register, output register).
- Outputs change only on a good frame, on reset, or on timeout (optional feature).
- Reset mid-frame: the partial frame is discarded. The first latch after reset then gives frame_err unless exactly NUM_BITS clocks preceded it.
- Inputs are assumed to stay high/low for at least 2 clk cycles per level (PMOD clock ≤ clk/4).

Optional Feature:
- Macro GAMEPAD_PMOD_RX_TIMEOUT_EN.
- Defined:
  - A watchdog counter is cleared on every good frame and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES-1, buttons and present are cleared to 0 once. No frame_valid pulse is generated.
  - The counter then stays saturated until the next good frame.
  - The watchdog counter resets to 0.
- Undefined: no watchdog logic; outputs hold indefinitely.

Test Plan:
- Reset: assert rst asynchronously mid-clock -> buttons=0, present=0, frame_valid=0, frame_err=0 immediately; release, idle 100 cycles -> no pulses.
- Good frame, NUM_CTRL=2: shift controller1=12'hFFF then controller0=12'h801 (B+R), latch -> frame_valid pulse 4 cycles after latch edge; buttons=24'h000801, present=2'b01.
- Both present: ctrl1=12'h0F0, ctrl0=12'h00A, latch -> buttons=24'h0F000A, present=2'b11; re-send with ctrl0=12'h000 -> buttons=24'h0F0000.
- Short frame: 23 clocks then latch -> frame_err pulse, no frame_valid, buttons unchanged; following correct 24-bit frame -> frame_valid, new values.
- Simultaneous edges: 23 clocks, then 24th clock and latch rising in the same cycle -> good frame accepted with the 24th bit included.
- With GAMEPAD_PMOD_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000: good frame buttons=24'h000100, then no latch for 1000 cycles -> buttons=0, present=0, no frame_valid; next good frame restores values.

Source files
------------

// File: rtl/gamepad_pmod_rx.sv
// Gamepad PMOD serial receiver: syncs data/clk/latch, shifts a frame, publishes masked buttons.
// Optional watchdog clear of stale outputs: define GAMEPAD_PMOD_RX_TIMEOUT_EN.
module gamepad_pmod_rx #(
  parameter int NUM_CTRL       = 2,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pmod_data,
  input  logic                     pmod_clk,
  input  logic                     pmod_latch,
  output logic [12*NUM_CTRL-1:0]   buttons,
  output logic [NUM_CTRL-1:0]      present,
  output logic                     frame_valid,
  output logic                     frame_err
);

  localparam int NUM_BITS = 12 * NUM_CTRL;
  localparam int CW       = $clog2(NUM_BITS + 2);

  logic [1:0] d_sync;
  logic [2:0] c_sync;
  logic [2:0] l_sync;
  logic       clk_rise;
  logic       latch_rise;

  logic [NUM_BITS-1:0] sr;
  logic [NUM_BITS-1:0] sr_nxt;
  logic [CW-1:0]       bitcnt;
  logic [CW-1:0]       cnt_nxt;

  logic [NUM_BITS-1:0] btn_c;
  logic [NUM_CTRL-1:0] pres_c;

  logic                ev_good;
  logic                ev_bad;
  logic [NUM_BITS-1:0] ev_btn;
  logic [NUM_CTRL-1:0] ev_pres;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sync <= '0;
      c_sync <= '0;
      l_sync <= '0;
    end else begin
      d_sync <= {d_sync[0], pmod_data};
      c_sync <= {c_sync[1:0], pmod_clk};
      l_sync <= {l_sync[1:0], pmod_latch};
    end
  end

  assign clk_rise   = c_sync[1] & ~c_sync[2];
  assign latch_rise = l_sync[1] & ~l_sync[2];

  // A latch in the same cycle as a shift sees the post-shift state.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = bitcnt;
    if (clk_rise) begin
      sr_nxt = {sr[NUM_BITS-2:0], d_sync[1]};
      if (bitcnt != CW'(NUM_BITS + 1))
        cnt_nxt = bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      bitcnt <= '0;
    end else begin
      sr     <= sr_nxt;
      bitcnt <= latch_rise ? '0 : cnt_nxt;
    end
  end

  // An all-ones slice means the controller is absent.
  always_comb begin
    btn_c  = '0;
    pres_c = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      pres_c[k] = ~&sr_nxt[12*k +: 12];
      if (pres_c[k])
        btn_c[12*k +: 12] = sr_nxt[12*k +: 12];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_good <= 1'b0;
      ev_bad  <= 1'b0;
      ev_btn  <= '0;
      ev_pres <= '0;
    end else begin
      ev_good <= latch_rise && (cnt_nxt == CW'(NUM_BITS));
      ev_bad  <= latch_rise && (cnt_nxt != CW'(NUM_BITS));
      if (latch_rise) begin
        ev_btn  <= btn_c;
        ev_pres <= pres_c;
      end
    end
  end

`ifdef GAMEPAD_PMOD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd;
  logic          wd_hit;

  assign wd_hit = (wd == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd <= '0;
    else if (ev_good)
      wd <= '0;
    else if (wd != TW'(TIMEOUT_CYCLES))
      wd <= wd + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buttons     <= '0;
      present     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= ev_good;
      frame_err   <= ev_bad;
      if (ev_good) begin
        buttons <= ev_btn;
        present <= ev_pres;
      end
`ifdef GAMEPAD_PMOD_RX_TIMEOUT_EN
      else if (wd_hit) begin
        buttons <= '0;
        present <= '0;
      end
`endif
    end
  end

endmodule
